// File: rtl/alu_seg_display.sv
// alu_seg_display: latches an ALU result/opcode pair and scans it onto a
// 4-digit common-anode seven-segment display as "op. _ hi lo".
module alu_seg_display #(
  parameter int RES_W       = 8,
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RES_W-1:0] result_in,
  input  logic [2:0]       opcode_in,
  input  logic             load,
  input  logic             freeze,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    DIGIT_RES_LO = 2'd0,
    DIGIT_RES_HI = 2'd1,
    DIGIT_BLANK  = 2'd2,
    DIGIT_OP     = 2'd3
  } digit_t;

  logic [7:0]    held_res;
  logic [2:0]    held_op;
  logic [PW-1:0] presc;
  logic          wrap;
  digit_t        digit;
  digit_t        digit_next;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Freeze only gates capture; the scan keeps running regardless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_res <= 8'h00;
      held_op  <= 3'd0;
    end else if (load && !freeze) begin
      held_res <= 8'(result_in);
      held_op  <= opcode_in;
    end
  end

  assign wrap = (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (wrap) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign digit_next = wrap ? digit_t'(digit + 2'd1) : digit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit <= DIGIT_RES_LO;
    end else begin
      digit <= digit_next;
    end
  end

  // Decode from the upcoming digit so anode and content switch on the same
  // edge as the scan index; held values are the pre-edge ones.
  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    case (digit_next)
      DIGIT_RES_LO: begin
        an_next  = 4'b1110;
        seg_next = hex7(held_res[3:0]);
      end
      DIGIT_RES_HI: begin
        an_next = 4'b1101;
        if (!(BLANK_LZ && (held_res[7:4] == 4'h0))) begin
          seg_next = hex7(held_res[7:4]);
        end
      end
      DIGIT_BLANK: begin
        an_next = 4'b1011;
      end
      default: begin
        an_next  = 4'b0111;
        seg_next = hex7({1'b0, held_op});
        dp_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_alu_seg_display.sv
// tb_alu_seg_display: checks three display configurations against a
// cycle-count based model, a vector table and hand-built corner sequences.
module tb_alu_seg_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] result_in;
  logic [2:0] opcode_in;
  logic       load;
  logic       freeze;

  logic [3:0] an_m, an_n, an_w;
  logic [6:0] seg_m, seg_n, seg_w;
  logic       dp_m, dp_n, dp_w;

  int tests_run = 0;
  int tests_failed = 0;

  int m_cnt;
  int m_res;
  int m_op;

  logic [6:0] hex_tab [16];
  logic [6:0] seen_seg [4];
  logic       seen_dp [4];
  logic [6:0] seen_nlz1;
  logic [6:0] seen_w4 [4];

  typedef struct {
    logic [7:0] res;
    logic [2:0] op;
    logic       frz;
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] s3;
    logic [6:0] s1_nlz;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  alu_seg_display #(.RES_W(8), .REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .result_in(result_in), .opcode_in(opcode_in),
    .load(load), .freeze(freeze), .an(an_m), .seg(seg_m), .dp(dp_m)
  );

  alu_seg_display #(.RES_W(8), .REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_nlz (
    .clk(clk), .rst(rst), .result_in(result_in), .opcode_in(opcode_in),
    .load(load), .freeze(freeze), .an(an_n), .seg(seg_n), .dp(dp_n)
  );

  alu_seg_display #(.RES_W(4), .REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut_w4 (
    .clk(clk), .rst(rst), .result_in(result_in[3:0]), .opcode_in(opcode_in),
    .load(load), .freeze(freeze), .an(an_w), .seg(seg_w), .dp(dp_w)
  );

  // Expected pins for a given scan position, straight from the digit map.
  function automatic logic [11:0] model_out(input int idx, input int res,
                                            input int op, input bit blz);
    int nib;
    nib = (res / 16) % 16;
    case (idx)
      0: return {4'b1110, hex_tab[res % 16], 1'b1};
      1: begin
        if (blz && nib == 0) return {4'b1101, 7'h7F, 1'b1};
        return {4'b1101, hex_tab[nib], 1'b1};
      end
      2: return {4'b1011, 7'h7F, 1'b1};
      default: return {4'b0111, hex_tab[op % 8], 1'b0};
    endcase
  endfunction

  task automatic check_output(input string name, input logic [11:0] got,
                              input logic [11:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  task automatic check_reset_pins(input string name);
    check_output({name, "_main"}, {an_m, seg_m, dp_m}, {4'hF, 7'h7F, 1'b1});
    check_output({name, "_nlz"},  {an_n, seg_n, dp_n}, {4'hF, 7'h7F, 1'b1});
    check_output({name, "_w4"},   {an_w, seg_w, dp_w}, {4'hF, 7'h7F, 1'b1});
  endtask

  task automatic clear_seen();
    for (int d = 0; d < 4; d++) begin
      seen_seg[d] = 7'h55;
      seen_dp[d]  = 1'bx;
      seen_w4[d]  = 7'h55;
    end
    seen_nlz1 = 7'h55;
  endtask

  // One clock: sample the inputs the edge will see, then compare all three
  // instances against the model and advance the model's held values.
  task automatic apply_stimulus();
    logic pre_load, pre_freeze, pre_rst;
    int   pre_res, pre_op, idx;
    pre_load   = load;
    pre_freeze = freeze;
    pre_rst    = rst;
    pre_res    = int'(result_in);
    pre_op     = int'(opcode_in);
    @(posedge clk);
    #1;
    if (!pre_rst) begin
      m_cnt = 0;
      m_res = 0;
      m_op  = 0;
      check_reset_pins("held_reset");
    end else begin
      m_cnt++;
      idx = (m_cnt / DIV) % 4;
      check_output("scan_main", {an_m, seg_m, dp_m}, model_out(idx, m_res, m_op, 1'b1));
      check_output("scan_nlz",  {an_n, seg_n, dp_n}, model_out(idx, m_res, m_op, 1'b0));
      check_output("scan_w4",   {an_w, seg_w, dp_w}, model_out(idx, m_res % 16, m_op, 1'b1));
      seen_seg[idx] = seg_m;
      seen_dp[idx]  = dp_m;
      seen_w4[idx]  = seg_w;
      if (idx == 1) seen_nlz1 = seg_n;
      if (pre_load && !pre_freeze) begin
        m_res = pre_res;
        m_op  = pre_op;
      end
    end
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{8'h3A, 3'd5, 1'b0, 7'h08, 7'h30, 7'h12, 7'h30};
    vecs[1] = '{8'hFF, 3'd7, 1'b1, 7'h08, 7'h30, 7'h12, 7'h30};
    vecs[2] = '{8'hFF, 3'd7, 1'b0, 7'h0E, 7'h0E, 7'h78, 7'h0E};
    vecs[3] = '{8'h07, 3'd2, 1'b0, 7'h78, 7'h7F, 7'h24, 7'h40};
    vecs[4] = '{8'h00, 3'd0, 1'b0, 7'h40, 7'h7F, 7'h40, 7'h40};
    vecs[5] = '{8'hB4, 3'd6, 1'b0, 7'h19, 7'h03, 7'h02, 7'h03};
    vecs[6] = '{8'h5C, 3'd1, 1'b0, 7'h46, 7'h12, 7'h79, 7'h12};

    rst = 1'b0; load = 1'b0; freeze = 1'b0;
    result_in = 8'h00; opcode_in = 3'd0;
    m_cnt = 0; m_res = 0; m_op = 0;
    #12;
    check_reset_pins("reset");
    rst = 1'b1;

    // Idle scan from reset: zero result and opcode on every digit.
    clear_seen();
    repeat (32) apply_stimulus();
    check_output("idle_idx0", {5'b0, seen_seg[0]}, {5'b0, 7'h40});
    check_output("idle_idx1", {5'b0, seen_seg[1]}, {5'b0, 7'h7F});
    check_output("idle_idx2", {5'b0, seen_seg[2]}, {5'b0, 7'h7F});
    check_output("idle_idx3", {4'b0, seen_seg[3], seen_dp[3]}, {4'b0, 7'h40, 1'b0});

    for (int v = 0; v < 7; v++) begin
      result_in = vecs[v].res;
      opcode_in = vecs[v].op;
      freeze    = vecs[v].frz;
      load      = 1'b1;
      apply_stimulus();
      load      = 1'b0;
      freeze    = 1'b0;
      result_in = 8'($urandom);
      opcode_in = 3'($urandom);
      clear_seen();
      repeat (16) apply_stimulus();
      check_output($sformatf("vec%0d_idx0", v), {5'b0, seen_seg[0]}, {5'b0, vecs[v].s0});
      check_output($sformatf("vec%0d_idx1", v), {5'b0, seen_seg[1]}, {5'b0, vecs[v].s1});
      check_output($sformatf("vec%0d_idx3", v), {4'b0, seen_seg[3], seen_dp[3]},
                   {4'b0, vecs[v].s3, 1'b0});
      check_output($sformatf("vec%0d_nlz1", v), {5'b0, seen_nlz1}, {5'b0, vecs[v].s1_nlz});
    end

    // Asynchronous reset between edges must blank the display at once.
    #3;
    rst = 1'b0;
    #1;
    check_reset_pins("async_reset");
    apply_stimulus();
    rst = 1'b1;
    clear_seen();
    repeat (16) apply_stimulus();
    check_output("post_reset_idx0", {5'b0, seen_seg[0]}, {5'b0, 7'h40});
    check_output("post_reset_idx1", {5'b0, seen_seg[1]}, {5'b0, 7'h7F});
    check_output("post_reset_idx3", {5'b0, seen_seg[3]}, {5'b0, 7'h40});

    // Load landing on the wrap into digit 0: old value for one clock.
    result_in = 8'h13; opcode_in = 3'd0; load = 1'b1;
    apply_stimulus();
    load = 1'b0;
    for (int g = 0; g < 64 && ((m_cnt + 1) % (4 * DIV)) != 0; g++) apply_stimulus();
    result_in = 8'h4C; opcode_in = 3'd0; load = 1'b1;
    apply_stimulus();
    load = 1'b0;
    check_output("wrap_old_w4",   {an_w, seg_w, dp_w}, {4'b1110, 7'h30, 1'b1});
    check_output("wrap_old_main", {an_m, seg_m, dp_m}, {4'b1110, 7'h30, 1'b1});
    apply_stimulus();
    check_output("wrap_new_w4",   {an_w, seg_w, dp_w}, {4'b1110, 7'h46, 1'b1});
    check_output("wrap_new_main", {an_m, seg_m, dp_m}, {4'b1110, 7'h46, 1'b1});
    clear_seen();
    repeat (16) apply_stimulus();
    check_output("w4_idx0", {5'b0, seen_w4[0]}, {5'b0, 7'h46});
    check_output("w4_idx1", {5'b0, seen_w4[1]}, {5'b0, 7'h7F});
    check_output("w4_idx3", {5'b0, seen_w4[3]}, {5'b0, 7'h40});
    check_output("main_hi_nib", {5'b0, seen_seg[1]}, {5'b0, 7'h19});

    // Random load/freeze traffic against the model.
    repeat (300) begin
      load      = ($urandom_range(0, 3) == 0);
      freeze    = ($urandom_range(0, 3) == 0);
      result_in = 8'($urandom);
      opcode_in = 3'($urandom);
      apply_stimulus();
    end
    load = 1'b0;
    freeze = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
